// File: rtl/loop_report_pkg.sv
// Shared types for the loop report collector: FSM state encoding, field
// widths and the packed run record (count, first, last, sum, err).
package loop_report_pkg;

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned SUM_W     = 8;
    localparam int unsigned SUM_EXT_W = SUM_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [IDX_W-1:0] first;
        logic [IDX_W-1:0] last;
        logic [SUM_W-1:0] sum;
        logic             err;
    } rec_t;

endpackage

// File: rtl/loop_seq_checker.sv
// Combinational loop-sequence checker.
// Flags an iteration index that is out of range (>= LIMIT) or, once a run
// has started (count != 0), one that does not follow the previous index.
//   beat      : index carried by the iteration beat being accepted
//   last      : index of the previous iteration beat in this run
//   count     : iteration beats already accepted in this run
//   violation : combinational error indication for this beat
module loop_seq_checker
    import loop_report_pkg::*;
#(
    parameter int unsigned LIMIT = 10
) (
    input  logic [IDX_W-1:0] beat,
    input  logic [IDX_W-1:0] last,
    input  logic [CNT_W-1:0] count,
    output logic             violation
);

    logic range_err_c;
    logic step_err_c;

    // Step check is done one bit wider so last=15 expects 16, never 0.
    always_comb begin
        range_err_c = 32'(beat) >= LIMIT;
        step_err_c  = (count != '0) &&
                      ((IDX_W + 1)'(beat) != ((IDX_W + 1)'(last) + (IDX_W + 1)'(1)));
        violation   = range_err_c | step_err_c;
    end

endmodule

// File: rtl/loop_report_collector.sv
// Loop report collector: accumulates iteration beats of one loop run and
// emits a single summary record when the run's done beat arrives.
// Optional sequence checking is compiled in with macro LOOP_REPORT_CHECK_EN;
// without it out_err is always 0.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : beat handshake (in_index, in_done)
//   out_valid/out_ready  : record handshake
//   out_count/first/last/sum/err : record fields, zero while out_valid=0
module loop_report_collector
    import loop_report_pkg::*;
#(
    parameter int unsigned LIMIT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic             in_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [IDX_W-1:0] out_first,
    output logic [IDX_W-1:0] out_last,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_err
);

    // Indices are IDX_W bits wide, so a larger LIMIT can never be reached.
    if (LIMIT > (1 << IDX_W)) begin : g_limit_range
        $error("loop_report_collector: LIMIT exceeds index range");
    end

    state_e state_q, state_d;
    rec_t   acc_q, acc_d;
    rec_t   out_rec_q, out_rec_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;

    logic                 accept_c;
    logic                 violation_c;
    logic [SUM_EXT_W-1:0] sum_ext_c;

    assign accept_c = in_valid & in_ready_q;

`ifdef LOOP_REPORT_CHECK_EN
    loop_seq_checker #(
        .LIMIT (LIMIT)
    ) u_seq_checker (
        .beat      (in_index),
        .last      (acc_q.last),
        .count     (acc_q.count),
        .violation (violation_c)
    );
`else
    assign violation_c = 1'b0;
`endif

    // State and record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_rec_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_rec_q   <= out_rec_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, accumulation and record capture.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_rec_d   = out_rec_q;
        out_valid_d = out_valid_q;
        sum_ext_c   = SUM_EXT_W'(acc_q.sum) + SUM_EXT_W'(in_index);

        case (state_q)
            IDLE, COLLECT: begin
                if (accept_c) begin
                    if (in_done) begin
                        out_rec_d   = acc_q;
                        out_valid_d = 1'b1;
                        state_d     = EMIT;
                    end else begin
                        if (acc_q.count != CNT_MAX) begin
                            acc_d.count = acc_q.count + CNT_W'(1);
                        end
                        acc_d.sum  = sum_ext_c[SUM_W] ? SUM_MAX : sum_ext_c[SUM_W-1:0];
                        acc_d.last = in_index;
                        if (acc_q.count == '0) begin
                            acc_d.first = in_index;
                        end
                        acc_d.err = acc_q.err | violation_c;
                        state_d   = COLLECT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    acc_d       = '0;
                    out_rec_d   = '0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready tracks the upcoming state, so it is low in EMIT.
        in_ready_d = (state_d != EMIT);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = out_rec_q.count;
    assign out_first = out_rec_q.first;
    assign out_last  = out_rec_q.last;
    assign out_sum   = out_rec_q.sum;
    assign out_err   = out_rec_q.err;

endmodule

// File: tb/tb_loop_report_collector.sv
// Bench for loop_report_collector: table of loop runs with expected records,
// scoreboard queue checked by a record monitor, plus hand-written sequences
// for latency, backpressure and mid-run reset.
module tb_loop_report_collector;
    import loop_report_pkg::*;

`ifdef LOOP_REPORT_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IDX_W-1:0] in_index = '0;
    logic             in_done = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] out_count;
    logic [IDX_W-1:0] out_first;
    logic [IDX_W-1:0] out_last;
    logic [SUM_W-1:0] out_sum;
    logic             out_err;

    int checks   = 0;
    int failures = 0;

    rec_t exp_q[$];
    rec_t mon_exp;

    typedef struct {
        int               n;
        logic [IDX_W-1:0] idx0;
        int               step;
        logic [CNT_W-1:0] cnt;
        logic [IDX_W-1:0] first;
        logic [IDX_W-1:0] last;
        logic [SUM_W-1:0] sum;
        logic             err_chk;
    } vec_t;

    vec_t vecs[8];

    loop_report_collector #(
        .LIMIT (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_done   (in_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_first (out_first),
        .out_last  (out_last),
        .out_sum   (out_sum),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record monitor: pops the scoreboard on every record handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rec_count", int'(out_count), int'(mon_exp.count));
                    check("rec_first", int'(out_first), int'(mon_exp.first));
                    check("rec_last",  int'(out_last),  int'(mon_exp.last));
                    check("rec_sum",   int'(out_sum),   int'(mon_exp.sum));
                    check("rec_err",   int'(out_err),   int'(mon_exp.err));
                end
            end else if (!out_valid) begin
                check("idle_outputs_zero",
                      int'(|{out_count, out_first, out_last, out_sum, out_err}), 0);
            end
        end
    end

    // Offer one beat from the drive point (just after a rising edge) and
    // return at the drive point after the edge that accepted it.
    task automatic drive_beat(input logic [IDX_W-1:0] idx, input logic done);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_index = idx;
        in_done  = done;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_done  = 1'b0;
        in_index = '0;
    endtask

    task automatic run_vec(input vec_t v);
        rec_t e;
        for (int k = 0; k < v.n; k++) begin
            drive_beat(IDX_W'(int'(v.idx0) + k * v.step), 1'b0);
        end
        check("pre_done_out_valid", int'(out_valid), 0);
        e.count = v.cnt;
        e.first = v.first;
        e.last  = v.last;
        e.sum   = v.sum;
        e.err   = CHK_EN & v.err_chk;
        exp_q.push_back(e);
        drive_beat('0, 1'b1);
    endtask

    initial begin
        vecs[0] = '{3,  4'd7,  1, 5'd3,  4'd7,  4'd9,  8'd24,  1'b0};
        vecs[1] = '{0,  4'd0,  0, 5'd0,  4'd0,  4'd0,  8'd0,   1'b0};
        vecs[2] = '{2,  4'd2,  2, 5'd2,  4'd2,  4'd4,  8'd6,   1'b1};
        vecs[3] = '{1,  4'd12, 0, 5'd1,  4'd12, 4'd12, 8'd12,  1'b1};
        vecs[4] = '{20, 4'd15, 0, 5'd20, 4'd15, 4'd15, 8'd255, 1'b1};
        vecs[5] = '{35, 4'd15, 0, 5'd31, 4'd15, 4'd15, 8'd255, 1'b1};
        vecs[6] = '{10, 4'd0,  1, 5'd10, 4'd0,  4'd9,  8'd45,  1'b0};
        vecs[7] = '{4,  4'd9,  1, 5'd4,  4'd9,  4'd12, 8'd42,  1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready",  int'(in_ready),  0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_sum",   int'(out_sum),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        // Table of runs with the record accepted immediately.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            @(negedge clk);
            check("latency_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end

        // Backpressure: record held for five cycles, accepted on the sixth.
        out_ready = 1'b0;
        begin
            vec_t v;
            v = '{3, 4'd7, 1, 5'd3, 4'd7, 4'd9, 8'd24, 1'b0};
            run_vec(v);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready",  int'(in_ready),  0);
            check("bp_count",     int'(out_count), 3);
            check("bp_first",     int'(out_first), 7);
            check("bp_last",      int'(out_last),  9);
            check("bp_sum",       int'(out_sum),   24);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready",  int'(in_ready),  1);

        // Reset in the middle of a run discards the partial accumulation.
        drive_beat(4'd3, 1'b0);
        drive_beat(4'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready",  int'(in_ready),  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release_in_ready", int'(in_ready), 1);
        check("midrst_release_out_valid", int'(out_valid), 0);
        begin
            vec_t v;
            v = '{1, 4'd5, 0, 5'd1, 4'd5, 4'd5, 8'd5, 1'b0};
            run_vec(v);
        end

        // Let the monitor consume every expected record.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loop_report_collector.md
LOOP_REPORT_COLLECTOR -- requirements
Module: loop_report_collector

Interface
REQ-001 SHALL have parameter: LIMIT, 10, exclusive upper bound on a legal loop index.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream loop stage offers a beat.
REQ-005 SHALL have port: in_ready  output  1  collector accepts the offered beat.
REQ-006 SHALL have port: in_index  input  4  loop index carried by the beat.
REQ-007 SHALL have port: in_done  input  1  beat terminates the current loop run.
REQ-008 SHALL have port: out_valid  output  1  completed run record available.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the record.
REQ-010 SHALL have port: out_count  output  5  number of iteration beats in the run.
REQ-011 SHALL have port: out_first  output  4  index of the first iteration beat.
REQ-012 SHALL have port: out_last  output  4  index of the last iteration beat.
REQ-013 SHALL have port: out_sum  output  8  sum of iteration indices.
REQ-014 SHALL have port: out_err  output  1  sequence error flag for the run.

Function
REQ-015 SHALL implement states IDLE, COLLECT, EMIT; a beat is accepted when in_valid and in_ready are both 1.
REQ-016 SHALL drive in_ready=1 in IDLE and COLLECT, in_ready=0 in EMIT.
REQ-017 SHALL, on an accepted beat with in_done=0, increment count, add in_index to sum, set last=in_index, and set first=in_index when count was 0; IDLE->COLLECT.
REQ-018 SHALL, on an accepted beat with in_done=1, ignore its in_index for count/sum/first/last and move IDLE or COLLECT->EMIT.
REQ-019 SHALL allow an empty run: a done beat in IDLE yields a record with count=0, first=0, last=0, sum=0.
REQ-020 SHALL assert out_valid the cycle after the done beat is accepted (latency 1) and hold it and all out_* stable until out_ready=1.
REQ-021 SHALL, on out_valid and out_ready both 1, clear count/sum/first/last/err and go to IDLE; no input beat is accepted in that cycle.
REQ-022 SHALL saturate count at 31 and sum at 255; no wrap-around.
REQ-023 SHALL drive out_* from registers only; out_* are undefined-free (zero) when out_valid=0.

Reset
REQ-024 SHALL, with rst_n=0, immediately force state IDLE, out_valid=0, in_ready=0 while low, and all accumulators/out_* to 0.
REQ-025 SHALL discard any partial run or unaccepted record on reset mid-operation; first cycle after release state is IDLE with in_ready=1.

Configuration
REQ-026 SHALL gate sequence checking with macro LOOP_REPORT_CHECK_EN.
REQ-027 SHALL, when LOOP_REPORT_CHECK_EN is defined, set sticky err for the run if an iteration beat has in_index>=LIMIT, or in COLLECT has in_index!=last+1.
REQ-028 SHALL, when LOOP_REPORT_CHECK_EN is undefined, tie out_err to 0 and include no checking logic.

Structure
REQ-029 SHALL place the state enum and a packed record struct (count, first, last, sum, err) in package loop_report_pkg.
REQ-030 SHALL implement the check logic in sub-module loop_seq_checker (inputs beat, last, count; output violation).

Verification
REQ-031 SHALL cover: beats idx 7,8,9 then done -> one record count=3 first=7 last=9 sum=24 err=0, out_valid one cycle after done.
REQ-032 SHALL cover: done only -> record count=0 sum=0 err=0.
REQ-033 SHALL cover: record with out_ready=0 for 5 cycles -> out_valid held, in_ready=0, fields stable; accepted on sixth cycle.
REQ-034 SHALL cover: with LOOP_REPORT_CHECK_EN, beats 2,4 then done -> err=1; beat 12 -> err=1; without macro same stimulus -> err=0.
REQ-035 SHALL cover: 20 beats of idx 15 (no check) -> count=20, sum saturates 255; 35 beats -> count=31.
REQ-036 SHALL cover: rst_n low after beats 3,4 -> out_valid=0; next run 5 then done -> count=1 sum=5.
